// File: rtl/rv_div_ctrl.sv
// Issue/retire sequencer between RV64M dispatch and the radix-4 SRT divider.
// Optional `RV_DIV_REUSE_EN keeps the last divider pass for same-operand reuse.
module rv_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_vld_o,
    output logic [XLEN-1:0]  div_op1_o,
    output logic [XLEN-1:0]  div_op2_o,
    input  logic             div_rdy_i,
    input  logic [XLEN-1:0]  div_quo_i,
    input  logic [XLEN-1:0]  div_rem_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WBUSY, S_WDONE, S_FIXUP, S_RESP
    } state_t;

    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    state_t state, state_nxt;

    logic        acc, f_uns, f_rem;
    logic [63:0] pa, pb;
    logic        b_zero, b_ovf, b_big, byp, ge, fix_in, hit;
    logic [63:0] byp_q, byp_r, ent_q_v, ent_r_v;
    logic        word_q, rem_q, fix_q, a0_q;
    logic [63:0] b_q, q_q, r_q;
    logic [63:0] fr, fq, fr2;
    logic        fge, wd_cap, fin_raw, fin_fix;

    function automatic logic [63:0] res_sel(
        input logic [63:0] q,
        input logic [63:0] r,
        input logic        rem,
        input logic        word
    );
        logic [63:0] v;
        v = rem ? r : q;
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    assign acc   = in_vld & in_rdy;
    assign f_uns = in_funct3[2] & in_funct3[0];
    assign f_rem = in_funct3[2] & in_funct3[1];

    always_comb begin
        pa = in_rs1;
        pb = in_rs2;
        if (in_word) begin
            if (f_uns) begin
                pa = {32'b0, in_rs1[31:0]};
                pb = {32'b0, in_rs2[31:0]};
            end else begin
                pa = {{32{in_rs1[31]}}, in_rs1[31:0]};
                pb = {{32{in_rs2[31]}}, in_rs2[31:0]};
            end
        end
    end

    assign b_zero = (pb == 64'd0);
    assign b_ovf  = ~f_uns & ~in_word & (pa == MIN_NEG) & (pb == '1);
    assign b_big  = f_uns & pb[63];
    assign byp    = b_zero | b_ovf | b_big;
    assign ge     = (pa >= pb);
    // Unsigned dividend with top bit set: halve it, rebuild in FIXUP.
    assign fix_in = f_uns & pa[63] & ~pb[63];

    always_comb begin
        byp_q = {63'd0, ge};
        byp_r = ge ? pa - pb : pa;
        if (b_zero) begin
            byp_q = '1;
            byp_r = pa;
        end else if (b_ovf) begin
            byp_q = pa;
            byp_r = 64'd0;
        end
    end

    // Remainder < divisor < 2^63, so the doubled value cannot overflow.
    assign fr  = (r_q << 1) | {63'd0, a0_q};
    assign fge = (fr >= b_q);
    assign fq  = (q_q << 1) | {63'd0, fge};
    assign fr2 = fge ? fr - b_q : fr;

    assign wd_cap  = (state == S_WDONE) & div_rdy_i;
    assign fin_raw = wd_cap & ~fix_q;
    assign fin_fix = (state == S_FIXUP);

`ifdef RV_DIV_REUSE_EN
    logic        ent_vld, ent_uns, ent_word, uns_q;
    logic [63:0] ent_a, ent_b, ent_q, ent_r, a_q;

    assign hit = ent_vld & (ent_a == pa) & (ent_b == pb)
               & (ent_uns == f_uns) & (ent_word == in_word);
    assign ent_q_v = ent_q;
    assign ent_r_v = ent_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_vld  <= 1'b0;
            ent_uns  <= 1'b0;
            ent_word <= 1'b0;
            ent_a    <= '0;
            ent_b    <= '0;
            ent_q    <= '0;
            ent_r    <= '0;
            a_q      <= '0;
            uns_q    <= 1'b0;
        end else begin
            if (acc) begin
                a_q   <= pa;
                uns_q <= f_uns;
            end
            if (fin_raw || fin_fix) begin
                ent_vld  <= 1'b1;
                ent_uns  <= uns_q;
                ent_word <= word_q;
                ent_a    <= a_q;
                ent_b    <= b_q;
                ent_q    <= fin_fix ? fq : div_quo_i;
                ent_r    <= fin_fix ? fr2 : div_rem_i;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign ent_q_v = '0;
    assign ent_r_v = '0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (acc) state_nxt = (byp | hit) ? S_RESP : S_ISSUE;
            S_ISSUE: if (div_rdy_i) state_nxt = S_WBUSY;
            S_WBUSY: if (!div_rdy_i) state_nxt = S_WDONE;
            S_WDONE: if (div_rdy_i) state_nxt = fix_q ? S_FIXUP : S_RESP;
            S_FIXUP: state_nxt = S_RESP;
            S_RESP:  if (out_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign div_vld_o = (state == S_ISSUE);
    assign out_vld   = (state == S_RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            in_rdy <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_rdy <= (state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data  <= '0;
            out_tag   <= '0;
            div_op1_o <= '0;
            div_op2_o <= '0;
            word_q    <= 1'b0;
            rem_q     <= 1'b0;
            fix_q     <= 1'b0;
            a0_q      <= 1'b0;
            b_q       <= '0;
            q_q       <= '0;
            r_q       <= '0;
        end else begin
            if (acc) begin
                out_tag <= in_tag;
                word_q  <= in_word;
                rem_q   <= f_rem;
                fix_q   <= fix_in;
                a0_q    <= pa[0];
                b_q     <= pb;
                if (byp) begin
                    out_data <= res_sel(byp_q, byp_r, f_rem, in_word);
                end else if (hit) begin
                    out_data <= res_sel(ent_q_v, ent_r_v, f_rem, in_word);
                end else begin
                    div_op1_o <= fix_in ? pa >> 1 : pa;
                    div_op2_o <= pb;
                end
            end
            if (wd_cap) begin
                q_q <= div_quo_i;
                r_q <= div_rem_i;
            end
            if (fin_raw) begin
                out_data <= res_sel(div_quo_i, div_rem_i, rem_q, word_q);
            end
            if (fin_fix) begin
                out_data <= res_sel(fq, fr2, rem_q, word_q);
            end
        end
    end

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Directed bench for rv_div_ctrl with a behavioural divider model.
module tb_rv_div_ctrl;

`ifdef RV_DIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [2:0]  in_funct3 = 3'b100;
    logic        in_word = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_tag;
    logic        div_vld_o;
    logic [63:0] div_op1_o, div_op2_o;
    logic        div_rdy;
    logic [63:0] div_quo, div_rem;

    int n_chk = 0;
    int n_fail = 0;
    int n_iss;
    int cnt;
    logic [63:0] last_op1;

    always #5 clk = ~clk;

    rv_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_funct3(in_funct3), .in_word(in_word),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_tag(out_tag),
        .div_vld_o(div_vld_o), .div_op1_o(div_op1_o),
        .div_op2_o(div_op2_o), .div_rdy_i(div_rdy),
        .div_quo_i(div_quo), .div_rem_i(div_rem)
    );

    // Divider: drops ready for 4 cycles after each handshake.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_rdy  <= 1'b1;
            cnt      <= 0;
            n_iss    <= 0;
            div_quo  <= '0;
            div_rem  <= '0;
            last_op1 <= '0;
        end else if (div_rdy && div_vld_o) begin
            div_rdy  <= 1'b0;
            cnt      <= 4;
            n_iss    <= n_iss + 1;
            last_op1 <= div_op1_o;
            div_quo  <= $signed(div_op1_o) / $signed(div_op2_o);
            div_rem  <= $signed(div_op1_o) % $signed(div_op2_o);
        end else if (!div_rdy) begin
            if (cnt == 1) div_rdy <= 1'b1;
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic w, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [4:0] tg,
                          input logic [63:0] exp, input int exp_iss,
                          input int exp_lat, input int hold);
        int base, lat, k;
        k = 0;
        @(negedge clk);
        while (!in_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_inrdy"}, 64'(in_rdy), 64'd1);
        in_funct3 = f3;
        in_word   = w;
        in_rs1    = r1;
        in_rs2    = r2;
        in_tag    = tg;
        in_vld    = 1'b1;
        base      = n_iss;
        @(posedge clk);
        #1 in_vld = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1 lat++;
            if (out_vld) break;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
        chk({nm, "_iss"}, 64'(n_iss - base), 64'(exp_iss));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold_data"}, out_data, exp);
            chk({nm, "_hold_vld"}, 64'(out_vld), 64'd1);
            chk({nm, "_hold_inrdy"}, 64'(in_rdy), 64'd0);
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
        chk({nm, "_done_vld"}, 64'(out_vld), 64'd0);
        chk({nm, "_done_inrdy"}, 64'(in_rdy), 64'd1);
    endtask

    initial begin
        int ri;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inrdy", 64'(in_rdy), 64'd0);
        chk("rst_outvld", 64'(out_vld), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_divvld", 64'(div_vld_o), 64'd0);
        chk("rst_op1", div_op1_o, 64'd0);
        chk("rst_op2", div_op2_o, 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1 chk("rel_inrdy", 64'(in_rdy), 64'd1);

        ri = REUSE ? 0 : 1;
        run_op("div_m7_2", 3'b100, 0, -64'sd7, 64'd2, 5'd1,
               64'hFFFF_FFFF_FFFF_FFFD, 1, 6, 0);
        run_op("rem_m7_2", 3'b110, 0, -64'sd7, 64'd2, 5'd2,
               64'hFFFF_FFFF_FFFF_FFFF, ri, REUSE ? 1 : 6, 0);
        run_op("divu_z", 3'b101, 0, 64'd5, 64'd0, 5'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
        run_op("remu_z", 3'b111, 0, 64'd5, 64'd0, 5'd4,
               64'd5, 0, 1, 0);
        run_op("div_ovf", 3'b100, 0, 64'h8000_0000_0000_0000, '1, 5'd5,
               64'h8000_0000_0000_0000, 0, 1, 0);
        run_op("rem_ovf", 3'b110, 0, 64'h8000_0000_0000_0000, '1, 5'd6,
               64'd0, 0, 1, 0);
        run_op("divu_fix", 3'b101, 0, '1, 64'd3, 5'd7,
               64'h5555_5555_5555_5555, 1, 7, 0);
        chk("fix_op1", last_op1, 64'h7FFF_FFFF_FFFF_FFFF);
        run_op("remu_fix", 3'b111, 0, '1, 64'd3, 5'd8,
               64'd0, ri, REUSE ? 1 : 7, 0);
        run_op("divuw", 3'b101, 1, 64'h1_8000_0000, 64'h1_0000_0001,
               5'd9, 64'hFFFF_FFFF_8000_0000, 1, 6, 3);
        run_op("divu_big", 3'b101, 0, '1, 64'h8000_0000_0000_0001,
               5'd10, 64'd1, 0, 1, 0);
        run_op("remu_big", 3'b111, 0, '1, 64'h8000_0000_0000_0001,
               5'd11, 64'h7FFF_FFFF_FFFF_FFFE, 0, 1, 0);
        run_op("divw_ovf", 3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF,
               5'd12, 64'hFFFF_FFFF_8000_0000, 1, 6, 0);
        run_op("div_f3_011", 3'b011, 0, 64'd20, -64'sd3, 5'd13,
               64'hFFFF_FFFF_FFFF_FFFA, 1, 6, 0);
        run_op("div_100_7", 3'b100, 0, 64'd100, 64'd7, 5'd14,
               64'd14, 1, 6, 0);
        run_op("rem_100_7", 3'b110, 0, 64'd100, 64'd7, 5'd15,
               64'd2, ri, REUSE ? 1 : 6, 0);

        // Reset while the divider is busy (WAIT_DONE).
        @(negedge clk);
        in_funct3 = 3'b100;
        in_word   = 1'b0;
        in_rs1    = 64'd50;
        in_rs2    = 64'd3;
        in_tag    = 5'd16;
        in_vld    = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_outvld", 64'(out_vld), 64'd0);
        chk("mid_rst_divvld", 64'(div_vld_o), 64'd0);
        chk("mid_rst_inrdy", 64'(in_rdy), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_inrdy", 64'(in_rdy), 64'd1);
        chk("mid_rel_outvld", 64'(out_vld), 64'd0);
        run_op("div_after_rst", 3'b110, 0, 64'd100, 64'd7, 5'd17,
               64'd2, 1, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
